// File: rtl/equiv_pkg.sv
// Shared types and helpers for the output-equivalence monitor.
// Holds the monitor state encoding and the warm-up length calculation.
package equiv_pkg;

  typedef enum logic [1:0] {
    StWarm,
    StCheck,
    StFailed
  } mon_state_e;

  // En-samples to discard before the aligned streams are comparable.
  function automatic int unsigned fill_cycles(input int unsigned lat_a,
                                              input int unsigned lat_b,
                                              input int unsigned warmup);
    return ((lat_a > lat_b) ? lat_a : lat_b) + warmup;
  endfunction

endpackage

// File: rtl/equiv_monitor_if.sv
// Bundle of compared buses and monitor results.
// master drives the samples, slave is the monitor.
interface equiv_monitor_if #(
  parameter int unsigned WIDTH = 91,
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic [WIDTH-1:0] y_a;
  logic [WIDTH-1:0] y_b;
  logic             mismatch;
  logic             fail;
  logic [CNT_W-1:0] mis_count;
  logic [CNT_W-1:0] sample_count;
  logic [CNT_W-1:0] first_idx;
  logic [WIDTH-1:0] first_diff;
  logic             checking;

  modport master (
    output en, y_a, y_b,
    input  mismatch, fail, mis_count, sample_count, first_idx, first_diff, checking
  );

  modport slave (
    input  en, y_a, y_b,
    output mismatch, fail, mis_count, sample_count, first_idx, first_diff, checking
  );

endinterface

// File: rtl/equiv_delay_line.sv
// En-qualified shift register used to align one compared stream.
// A depth of zero is a plain wire.
module equiv_delay_line #(
  parameter int unsigned WIDTH = 91,
  parameter int unsigned DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en_i};
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d = stage_q;
      if (en_i) begin
        stage_d[0] = d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/equiv_monitor.sv
// Compares two implementation outputs after latency alignment and warm-up,
// recording the first divergence and saturating mismatch/sample counts.
module equiv_monitor
  import equiv_pkg::*;
#(
  parameter int unsigned WIDTH     = 91,
  parameter int unsigned LAT_A     = 0,
  parameter int unsigned LAT_B     = 0,
  parameter int unsigned WARMUP    = 0,
  parameter int unsigned CNT_W     = 16,
  parameter bit          ASSERT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  equiv_monitor_if.slave  bus
);

  localparam int unsigned      Fill       = fill_cycles(LAT_A, LAT_B, WARMUP);
  localparam mon_state_e       ResetState = (Fill > 0) ? StWarm : StCheck;
  localparam logic [CNT_W-1:0] CntMax     = '1;

  logic [WIDTH-1:0] da;
  logic [WIDTH-1:0] db;

  equiv_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (LAT_A)
  ) u_dly_a (
    .clk  (clk),
    .rst  (rst),
    .en_i (bus.en),
    .d_i  (bus.y_a),
    .q_o  (da)
  );

  equiv_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (LAT_B)
  ) u_dly_b (
    .clk  (clk),
    .rst  (rst),
    .en_i (bus.en),
    .d_i  (bus.y_b),
    .q_o  (db)
  );

  mon_state_e       state_q, state_d;
  logic [31:0]      fill_q, fill_d;
  logic             mismatch_q, mismatch_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic [WIDTH-1:0] first_diff_q, first_diff_d;

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    mismatch_d   = 1'b0;
    fail_d       = fail_q;
    mis_cnt_d    = mis_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    first_idx_d  = first_idx_q;
    first_diff_d = first_diff_q;

    unique case (state_q)
      StWarm: begin
        if (bus.en) begin
          fill_d = fill_q + 32'd1;
          if (fill_d == Fill) begin
            state_d = StCheck;
          end
        end
      end
      StCheck, StFailed: begin
        if (bus.en) begin
          if (smp_cnt_q != CntMax) begin
            smp_cnt_d = smp_cnt_q + 1'b1;
          end
          if (da != db) begin
            mismatch_d = 1'b1;
            if (mis_cnt_q != CntMax) begin
              mis_cnt_d = mis_cnt_q + 1'b1;
            end
            // Only the first divergence is captured; later ones just count.
            if (state_q == StCheck) begin
              state_d      = StFailed;
              fail_d       = 1'b1;
              first_idx_d  = smp_cnt_q;
              first_diff_d = da ^ db;
            end
          end
        end
      end
      default: state_d = ResetState;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ResetState;
      fill_q       <= '0;
      mismatch_q   <= 1'b0;
      fail_q       <= 1'b0;
      mis_cnt_q    <= '0;
      smp_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_diff_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      mismatch_q   <= mismatch_d;
      fail_q       <= fail_d;
      mis_cnt_q    <= mis_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
      first_idx_q  <= first_idx_d;
      first_diff_q <= first_diff_d;
    end
  end

  assign bus.mismatch     = mismatch_q;
  assign bus.fail         = fail_q;
  assign bus.mis_count    = mis_cnt_q;
  assign bus.sample_count = smp_cnt_q;
  assign bus.first_idx    = first_idx_q;
  assign bus.first_diff   = first_diff_q;
  assign bus.checking     = (state_q != StWarm);

  // Simulation-only flag; immediate assertions carry no hardware.
  if (ASSERT_EN) begin : g_assert
    always_ff @(posedge clk) begin
      assert (!mismatch_q);
    end
  end

endmodule

// File: doc/equiv_monitor.md
EQUIV_MONITOR -- requirements
Module: equiv_monitor

Interface
REQ-001 Parameter WIDTH, default 91, bit width of each compared output bus.
REQ-002 Parameter LAT_A, default 0, cycles of alignment delay applied to y_a.
REQ-003 Parameter LAT_B, default 0, cycles of alignment delay applied to y_b.
REQ-004 Parameter WARMUP, default 0, extra en-samples ignored after alignment fill.
REQ-005 Parameter CNT_W, default 16, width of all counters.
REQ-006 Parameter ASSERT_EN, default 1, enables the simulation-only immediate assertion on mismatch.
REQ-007 clk  input  1  single clock; all state updates on posedge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 en  input  1  sample strobe; y_a/y_b are sampled only when en=1.
REQ-010 y_a  input  WIDTH  output of implementation A.
REQ-011 y_b  input  WIDTH  output of implementation B.
REQ-012 mismatch  output  1  one-cycle pulse, the compared sample differed.
REQ-013 fail  output  1  sticky; set at first mismatch.
REQ-014 mis_count  output  CNT_W  saturating count of mismatching samples.
REQ-015 sample_count  output  CNT_W  saturating count of compared samples.
REQ-016 first_idx  output  CNT_W  sample_count value of the first mismatching sample.
REQ-017 first_diff  output  WIDTH  y_a XOR y_b of the first mismatching sample.
REQ-018 checking  output  1  high while the state is CHECK or FAILED.

Function
REQ-019 Each of y_a and y_b passes through its own delay line of LAT_A or LAT_B stages, advancing only on en=1; a latency of 0 is a direct wire.
REQ-020 The state machine has three states, WARM, CHECK and FAILED.
REQ-021 After reset the state is WARM if FILL = max(LAT_A,LAT_B)+WARMUP > 0, otherwise CHECK.
REQ-022 In WARM, a fill counter increments on each en=1, and the state moves to CHECK on the en cycle that brings the counter to FILL.
REQ-023 In WARM, no comparison occurs and no output other than the fill counter changes.
REQ-024 In CHECK or FAILED, each en=1 cycle compares the aligned samples da and db with 2-state inequality.
REQ-025 On each such comparison, sample_count increments and saturates at all-ones.
REQ-026 mismatch is registered: it is high in the cycle after an en=1 cycle where da != db, and low in every other cycle.
REQ-027 On a mismatch, mis_count increments and saturates at all-ones.
REQ-028 On the first mismatch (CHECK -> FAILED), first_idx latches the pre-increment sample_count, first_diff latches da^db and fail sets, all taking effect in the same cycle as mismatch.
REQ-029 FAILED persists until rst, and later mismatches update only mismatch and mis_count.
REQ-030 With en=0, all state, counters and delay lines hold, and mismatch is 0.
REQ-031 If sample_count is saturated and a mismatch occurs, first_idx receives the saturated value.
REQ-032 When ASSERT_EN=1, simulation reports an assertion failure in the cycle mismatch is high; synthesis ignores this check.

Reset
REQ-033 rst clears all outputs, counters and delay-line stages to 0, and sets the state per REQ-021.
REQ-034 rst takes priority over en, and an en=1 in the same cycle as rst is discarded.
REQ-035 rst asserted mid-run, including in FAILED, fully restarts warm-up on the next cycle.

Structure
REQ-036 The state enumeration and the FILL computation function belong in a shared package, equiv_pkg.
REQ-037 The delay line shall be a sub-module, equiv_delay_line, parametrised by WIDTH and DEPTH, with en and synchronous reset; DEPTH=0 is a pass-through.
REQ-038 equiv_monitor shall instantiate equiv_delay_line twice.
REQ-039 Testbench tops shall instantiate equiv_monitor in place of a bare inline equality assertion.

Verification
REQ-040 Defaults, y_a=y_b=random for 100 en cycles -> mismatch never high, fail=0, sample_count=100, mis_count=0.
REQ-041 Defaults, y_b differs only in bit 90 on sample 7 (0-based) -> mismatch high one cycle later, fail=1, first_idx=7, first_diff=1<<90, mis_count=1.
REQ-042 LAT_A=2, LAT_B=0, y_b equal to y_a delayed 2 en-samples -> checking rises after 2 en cycles, and the run has no mismatch.
REQ-043 WARMUP=3, unequal inputs on the first 3 en cycles then equal -> fail=0, and sample_count excludes the 3 ignored samples.
REQ-044 CNT_W=4, 20 consecutive mismatches -> mis_count saturates at 15, and first_idx=0.
REQ-045 Reach FAILED, then pulse rst for one cycle with en=1 -> all outputs 0 the next cycle, and equal inputs afterwards never raise fail.
